// File: rtl/exp_arbiter_pkg.sv
// rtl/exp_arbiter_pkg.sv - shared state encoding and FP constants for exp_arbiter
package exp_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } arbState_e;

  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/exp_arbiter_rr.sv
// rtl/exp_arbiter_rr.sv - combinational round-robin arbiter, one-hot grant
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant
);

  int   idx;
  logic found;

  // Walk the requesters starting at ptr and wrap; the first valid one wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exp_arbiter.sv
// rtl/exp_arbiter.sv - shares one exponent unit among NUM_REQ requesters
module exp_arbiter
  import exp_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          exp_enb,
  output logic [DATA_WIDTH-1:0]         exp_x,
  input  logic                          exp_ack,
  input  logic [DATA_WIDTH-1:0]         exp_y,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  arbState_e             state, nxtState;
  logic [IDW-1:0]        ptr;
  logic [CW-1:0]         runCnt;
  logic [NUM_REQ-1:0]    grant;
  logic [IDW-1:0]        grantIdx;
  logic [IDW-1:0]        nextPtr;
  logic [DATA_WIDTH-1:0] selX;
  logic                  anyReq;
  logic                  timedOut;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PW     (IDW)
  ) u_rr (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(grant)
  );

  assign anyReq   = |req_valid;
  assign timedOut = (runCnt == CW'(TIMEOUT - 1));

  always_comb begin
    grantIdx = '0;
    nextPtr  = '0;
    selX     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grantIdx = IDW'(i);
        nextPtr  = (i == NUM_REQ - 1) ? '0 : IDW'(i + 1);
        selX     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    nxtState = state;
    case (state)
      IDLE:    if (anyReq) nxtState = RUN;
      RUN:     if (exp_ack || timedOut) nxtState = RESP;
      RESP:    if (rsp_ready) nxtState = IDLE;
      default: nxtState = IDLE;
    endcase
  end

  // The accept pulse is gated by rst_n so it drops the instant reset asserts.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign exp_enb   = (state == RUN);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      runCnt   <= '0;
      exp_x    <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= nxtState;
      case (state)
        IDLE: begin
          if (anyReq) begin
            exp_x  <= selX;
            rsp_id <= grantIdx;
            ptr    <= nextPtr;
            runCnt <= '0;
          end
        end
        RUN: begin
          if (exp_ack) begin
            rsp_data <= exp_y;
            rsp_err  <= 1'b0;
          end else if (timedOut) begin
            rsp_data <= DATA_WIDTH'(FP_ZERO);
            rsp_err  <= 1'b1;
          end else begin
            runCnt <= runCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_arbiter.sv
// tb/tb_exp_arbiter.sv - directed self-checking bench for exp_arbiter
module tb_exp_arbiter;
  import exp_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [DW-1:0]  rsp_data;
  logic           rsp_err;
  logic           exp_enb;
  logic [DW-1:0]  exp_x;
  logic           exp_ack;
  logic [DW-1:0]  exp_y;
  logic           busy;

  int   nCompared   = 0;
  int   nMismatched = 0;
  logic ackEnable;
  int   ackCnt      = 0;

  always #5 clk = ~clk;

  exp_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .exp_enb  (exp_enb),
    .exp_x    (exp_x),
    .exp_ack  (exp_ack),
    .exp_y    (exp_y),
    .busy     (busy)
  );

  // Exponent unit stand-in: acks on the 8th enabled cycle, result from a table.
  function automatic logic [31:0] expModel(input logic [31:0] x);
    case (x)
      32'h0000_0000: expModel = 32'h3F80_0000;
      32'h3F80_0000: expModel = 32'h402D_F854;
      default:       expModel = x ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  always @(posedge clk) ackCnt <= exp_enb ? ackCnt + 1 : 0;
  assign exp_ack = ackEnable && exp_enb && (ackCnt == 7);
  assign exp_y   = expModel(exp_x);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Called in the grant cycle; lat counts cycles from req_ready to rsp_valid.
  task automatic waitRsp(input logic [NR-1:0] after, output int lat, output int enbCnt);
    lat    = 0;
    enbCnt = 0;
    while (!rsp_valid && lat < 40) begin
      if (exp_enb) enbCnt++;
      tick();
      req_valid = after;
      lat++;
    end
    chk("rsp_valid_seen", rsp_valid, 1);
  endtask

  int             lat, enbCnt, b;
  logic           prevEnb;
  logic [NR-1:0]  fairExp [5];

  initial begin
    fairExp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ackEnable = 1'b1;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b0;
    prevEnb   = 1'b0;
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exp_enb", exp_enb, 0);
    chk("rst_exp_x", exp_x, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // single job on requester 2, X=0
    req_data[2*DW +: DW] = 32'h0;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    waitRsp(4'b0000, lat, enbCnt);
    chk("single_latency", lat, 9);
    chk("single_enb_cycles", enbCnt, 8);
    chk("single_id", rsp_id, 2);
    chk("single_data", rsp_data, FP_ONE);
    chk("single_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("single_done_valid", rsp_valid, 0);
    chk("single_done_busy", busy, 0);

    // accuracy on requester 1, X=1.0; requester 0 waits behind it
    req_data[1*DW +: DW] = 32'h3F80_0000;
    req_data[0*DW +: DW] = 32'h0;
    req_valid = 4'b0010;
    #1;
    chk("acc_ready", req_ready, 4'b0010);
    waitRsp(4'b0001, lat, enbCnt);
    chk("acc_latency", lat, 9);
    chk("acc_data", rsp_data, 32'h402D_F854);
    chk("acc_err", rsp_err, 0);
    chk("acc_id", rsp_id, 1);

    // backpressure: hold RESP for 5 cycles with requester 0 pending
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 32'h402D_F854);
      chk("bp_id", rsp_id, 1);
      chk("bp_no_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_release_grant", req_ready, 4'b0001);
    waitRsp(4'b0000, lat, enbCnt);
    chk("bp_next_id", rsp_id, 0);
    chk("bp_next_data", rsp_data, FP_ONE);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // timeout: the unit never acks
    ackEnable = 1'b0;
    req_data[3*DW +: DW] = 32'h4000_0000;
    req_valid = 4'b1000;
    #1;
    chk("to_ready", req_ready, 4'b1000);
    waitRsp(4'b0000, lat, enbCnt);
    chk("to_latency", lat, 16);
    chk("to_run_cycles", enbCnt, 15);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_data, 0);
    chk("to_id", rsp_id, 3);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    ackEnable = 1'b1;

    // fairness: all four held valid, responses consumed at once
    doReset();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      b = 0;
      while (req_ready == '0 && b < 40) begin
        prevEnb = exp_enb;
        tick();
        b++;
      end
      chk($sformatf("fair_grant%0d", j), req_ready, fairExp[j]);
      chk($sformatf("fair_enb_grant%0d", j), exp_enb, 0);
      if (j > 0) chk($sformatf("fair_enb_gap%0d", j), prevEnb, 0);
      prevEnb = exp_enb;
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    // reset in RUN cycle 3 aborts the job; next grant searches from 0
    doReset();
    req_valid = 4'b0010;
    #1;
    chk("rr_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0111;
    tick();
    tick();
    chk("rr_enb_run3", exp_enb, 1);
    chk("rr_x_run3", exp_x, 32'h3F80_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_enb", exp_enb, 0);
    chk("rr_busy", busy, 0);
    chk("rr_valid", rsp_valid, 0);
    chk("rr_req_ready", req_ready, 0);
    chk("rr_exp_x", exp_x, 0);
    chk("rr_rsp_id", rsp_id, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rr_regrant", req_ready, 4'b0001);
    tick();
    chk("rr_no_rsp", rsp_valid, 0);
    chk("rr_busy_again", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
